// File: rtl/helix_control_encode.sv
// HELIX control-link initiator: encodes register requests into 64-bit control
// packets and, for reads, waits (with timeout) for the matching status packet.
module helix_control_encode #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic [3:0]  req_lane_i,
  input  logic [1:0]  req_base_i,
  input  logic [15:0] req_adr_i,
  input  logic [15:0] req_dat_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [7:0]  drop_cnt_o,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tkeep,
  output logic [3:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast
);

  localparam logic [15:0] TX_HDR   = 16'hC751;
  localparam logic [15:0] RX_HDR   = 16'h57A7;
  localparam logic [1:0]  TYPE_RD  = 2'b10;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t      state;
  logic [1:0]  lat_type;
  logic [3:0]  lat_lane;
  logic [1:0]  lat_base;
  logic [15:0] lat_adr;
  logic [15:0] tmo_cnt;

  logic [21:0] req_a22;
  logic [15:0] req_d;
  logic [63:0] tx_pkt;
  logic        rx_beat;
  logic        rx_match;

  // WRITE (01) and UPDATE (11) carry data; READ and NOP send a zero data field
  assign req_a22 = {req_lane_i, req_base_i, req_adr_i};
  assign req_d   = req_type_i[0] ? req_dat_i : 16'h0000;
  assign tx_pkt  = {req_d[11:0], 4'h8, req_a22[11:0], req_d[15:12],
                    4'hF, req_type_i, req_a22[21:12], TX_HDR};

  assign rx_beat  = s_axis_tvalid & s_axis_tready;
  assign rx_match = rx_beat
                  && (s_axis_tdata[15:0] == RX_HDR)
                  && (s_axis_tkeep == 8'hFF) && s_axis_tlast
                  && (s_axis_tdata[31:28] == 4'hF) && (s_axis_tdata[51:48] == 4'h8)
                  && (s_axis_tdata[27:26] == TYPE_RD)
                  && (s_axis_tdata[25:22] == lat_lane)
                  && (s_axis_tdata[21:20] == lat_base)
                  && ({s_axis_tdata[19:16], s_axis_tdata[47:36]} == lat_adr);

  assign m_axis_tkeep = 8'hFF;
  assign m_axis_tuser = 4'h0;
  assign m_axis_tlast = 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      lat_type      <= 2'b00;
      lat_lane      <= 4'h0;
      lat_base      <= 2'b00;
      lat_adr       <= 16'h0000;
      tmo_cnt       <= 16'h0000;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= 16'h0000;
      rsp_err_o     <= 1'b0;
      drop_cnt_o    <= 8'h00;
      m_axis_tdata  <= 64'h0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      rsp_valid_o   <= 1'b0;

      // every accepted inbound beat that is not the awaited response is discarded
      if (rx_beat && !((state == WAIT_RSP) && rx_match) && (drop_cnt_o != 8'hFF))
        drop_cnt_o <= drop_cnt_o + 8'd1;

      case (state)
        IDLE: begin
          if (req_ready_o && req_valid_i) begin
            lat_type      <= req_type_i;
            lat_lane      <= req_lane_i;
            lat_base      <= req_base_i;
            lat_adr       <= req_adr_i;
            m_axis_tdata  <= tx_pkt;
            m_axis_tvalid <= 1'b1;
            req_ready_o   <= 1'b0;
            state         <= SEND;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            if (lat_type == TYPE_RD) begin
              tmo_cnt <= 16'h0000;
              state   <= WAIT_RSP;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_dat_o   <= 16'h0000;
              rsp_err_o   <= 1'b0;
              state       <= DONE;
            end
          end
        end
        WAIT_RSP: begin
          if (rx_match) begin
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= {s_axis_tdata[35:32], s_axis_tdata[63:52]};
            rsp_err_o   <= 1'b0;
            state       <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= 16'hFFFF;
            rsp_err_o   <= 1'b1;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_helix_control_encode.sv
// Bench for helix_control_encode: table vectors, hand-written corner sequences
// and random transactions against a field-arithmetic packet model.
module tb_helix_control_encode;

  localparam int unsigned TMO = 16;

  logic        aclk;
  logic        areset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_type_i;
  logic [3:0]  req_lane_i;
  logic [1:0]  req_base_i;
  logic [15:0] req_adr_i;
  logic [15:0] req_dat_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [7:0]  drop_cnt_o;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tkeep;
  logic [3:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  helix_control_encode #(.TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_lane_i(req_lane_i), .req_base_i(req_base_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .drop_cnt_o(drop_cnt_o),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  lane;
    logic [1:0]  base;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [63:0] exp_tx;
    logic [63:0] rsp;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model from field arithmetic on the 22-bit address
  function automatic logic [63:0] model_tx(input int unsigned t, input int unsigned lane,
                                           input int unsigned base, input int unsigned adr,
                                           input int unsigned dat);
    int unsigned a, d, w1, w2, w3;
    a  = lane * 262144 + base * 65536 + adr;
    d  = (t == 1 || t == 3) ? dat : 0;
    w1 = 'hF000 + t * 1024 + (a / 4096);
    w2 = (a % 4096) * 16 + d / 4096;
    w3 = (d % 4096) * 16 + 8;
    return {16'(w3), 16'(w2), 16'(w1), 16'hC751};
  endfunction

  function automatic logic [63:0] model_rsp(input int unsigned lane, input int unsigned base,
                                            input int unsigned adr, input int unsigned dat);
    int unsigned w1, w2, w3;
    w1 = 'hF000 + 2 * 1024 + lane * 64 + base * 16 + adr / 4096;
    w2 = (adr % 4096) * 16 + dat / 4096;
    w3 = (dat % 4096) * 16 + 8;
    return {16'(w3), 16'(w2), 16'(w1), 16'h57A7};
  endfunction

  task automatic beat(input logic [63:0] d, input logic [7:0] keep, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 64'h0;
    s_axis_tkeep  = 8'h00;
    s_axis_tlast  = 1'b0;
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset   = 1'b0;
    exp_drop = 0;
    tick();
  endtask

  // mode: 1 matching response, 2 bad beat then match, 3 no response (timeout)
  task automatic run_req(input logic [1:0] typ, input logic [3:0] lane, input logic [1:0] base,
                         input logic [15:0] adr, input logic [15:0] dat,
                         input logic [63:0] exp_tx, input int stall, input int mode,
                         input logic [63:0] rsp_word, input logic [15:0] exp_dat,
                         input int bad_kind);
    int k;
    logic [15:0] e_dat;
    logic        e_err;
    logic [63:0] bad;
    logic [7:0]  bkeep;
    logic        blast;
    k = 0;
    while (!req_ready_o && k < 50) begin
      tick();
      k++;
    end
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    m_axis_tready = (stall == 0);
    req_valid_i = 1'b1;
    req_type_i  = typ;
    req_lane_i  = lane;
    req_base_i  = base;
    req_adr_i   = adr;
    req_dat_i   = dat;
    tick();
    req_valid_i = 1'b0;
    req_dat_i   = ~dat;
    check("tx_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("tx_tdata", m_axis_tdata, exp_tx);
    check("req_ready_busy", 64'(req_ready_o), 64'd0);
    check("rsp_quiet_send", 64'(rsp_valid_o), 64'd0);
    if (stall > 0) begin
      for (int i = 1; i < stall; i++) begin
        tick();
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_tdata", m_axis_tdata, exp_tx);
        check("stall_req_ready", 64'(req_ready_o), 64'd0);
      end
      tick();
      m_axis_tready = 1'b1;
      check("stall_end_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("stall_rsp_quiet", 64'(rsp_valid_o), 64'd0);
    end
    tick();
    if (typ != 2'b10) begin
      e_dat = 16'h0000;
      e_err = 1'b0;
    end else begin
      check("rsp_quiet_wait", 64'(rsp_valid_o), 64'd0);
      check("tvalid_dropped", 64'(m_axis_tvalid), 64'd0);
      if (mode == 3) begin
        k = 0;
        while (!rsp_valid_o && k < 40) begin
          tick();
          k++;
        end
        check("timeout_latency", 64'(k), 64'(TMO));
        e_dat = 16'hFFFF;
        e_err = 1'b1;
      end else begin
        if (mode == 2) begin
          bad   = rsp_word;
          bkeep = 8'hFF;
          blast = 1'b1;
          case (bad_kind)
            0: bad = rsp_word ^ (64'h1 << 36);
            1: bad = rsp_word ^ (64'h1 << 22);
            2: bkeep = 8'h7F;
            3: blast = 1'b0;
            default: bad = rsp_word ^ 64'h1;
          endcase
          beat(bad, bkeep, blast);
          check("bad_beat_ignored", 64'(rsp_valid_o), 64'd0);
          check("bad_beat_drop", 64'(drop_cnt_o), 64'(exp_drop));
        end
        beat(rsp_word, 8'hFF, 1'b1);
        if (exp_drop > 0) exp_drop--;
        e_dat = exp_dat;
        e_err = 1'b0;
      end
    end
    check("rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("rsp_dat", 64'(rsp_dat_o), 64'(e_dat));
    check("rsp_err", 64'(rsp_err_o), 64'(e_err));
    check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    tick();
    check("rsp_pulse_end", 64'(rsp_valid_o), 64'd0);
    check("rsp_dat_hold", 64'(rsp_dat_o), 64'(e_dat));
    check("req_ready_back", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  t;
    logic [3:0]  ln;
    logic [1:0]  bs;
    logic [15:0] ad, dt, rd;
    int          md;

    req_valid_i = 1'b0; req_type_i = 2'b00; req_lane_i = 4'h0; req_base_i = 2'b00;
    req_adr_i = 16'h0; req_dat_i = 16'h0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 64'h0; s_axis_tkeep = 8'h00; s_axis_tlast = 1'b0;

    vecs[0] = '{2'b01, 4'h3, 2'b00, 16'h1234, 16'hABCD, 64'hBCD8_234A_F4C1_C751, 64'h0, 16'h0000};
    vecs[1] = '{2'b10, 4'h0, 2'b00, 16'h0010, 16'h9999, 64'h0008_0100_F800_C751,
                64'hA5A8_0105_F800_57A7, 16'h5A5A};
    vecs[2] = '{2'b11, 4'hF, 2'b11, 16'hFFFF, 16'h0001, 64'h0018_FFF0_FFFF_C751, 64'h0, 16'h0000};
    vecs[3] = '{2'b00, 4'h5, 2'b10, 16'hBEEF, 16'h1234, 64'h0008_EEF0_F16B_C751, 64'h0, 16'h0000};

    areset = 1'b1;
    #3;
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_sideband", {51'(m_axis_tkeep), m_axis_tuser, 8'(m_axis_tlast)},
          {51'h00FF, 4'h0, 8'h01});
    do_reset();
    check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

    for (int i = 0; i < 4; i++)
      run_req(vecs[i].typ, vecs[i].lane, vecs[i].base, vecs[i].adr, vecs[i].dat,
              vecs[i].exp_tx, 0, 1, vecs[i].rsp, vecs[i].exp_dat, 0);

    run_req(2'b10, 4'h0, 2'b00, 16'h0010, 16'h0, 64'h0008_0100_F800_C751, 0, 3, 64'h0, 16'h0, 0);

    // Mismatched address first, then the real response, then a stray beat in IDLE
    do_reset();
    run_req(2'b10, 4'h0, 2'b00, 16'h0010, 16'h0, 64'h0008_0100_F800_C751, 0, 2,
            64'hA5A8_0105_F800_57A7, 16'h5A5A, 0);
    check("drop_after_mismatch", 64'(drop_cnt_o), 64'd1);
    beat(64'hA5A8_0105_F800_57A7, 8'hFF, 1'b1);
    check("drop_after_stray", 64'(drop_cnt_o), 64'd2);
    check("stray_no_rsp", 64'(rsp_valid_o), 64'd0);

    run_req(2'b01, 4'h3, 2'b00, 16'h1234, 16'hABCD, 64'hBCD8_234A_F4C1_C751, 5, 1, 64'h0, 16'h0, 0);

    // Reset pulsed while waiting for a read response
    tick();
    req_valid_i = 1'b1; req_type_i = 2'b10; req_lane_i = 4'h1; req_base_i = 2'b01;
    req_adr_i = 16'h4321;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    #2 areset = 1'b1;
    #1;
    check("midrst_req_ready", 64'(req_ready_o), 64'd0);
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    check("midrst_drop", 64'(drop_cnt_o), 64'd0);
    check("midrst_rsp", {47'(rsp_dat_o), 16'(rsp_err_o), rsp_valid_o}, 64'h0);
    tick();
    areset   = 1'b0;
    exp_drop = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_spurious", 64'(rsp_valid_o), 64'd0);
    end
    run_req(2'b01, 4'h3, 2'b00, 16'h1234, 16'hABCD, 64'hBCD8_234A_F4C1_C751, 0, 1, 64'h0, 16'h0, 0);

    for (int n = 0; n < 60; n++) begin
      t  = 2'($urandom_range(0, 3));
      ln = 4'($urandom);
      bs = 2'($urandom);
      ad = 16'($urandom);
      dt = 16'($urandom);
      rd = 16'($urandom);
      md = $urandom_range(1, 3);
      run_req(t, ln, bs, ad, dt, model_tx(t, ln, bs, ad, dt), $urandom_range(0, 3), md,
              model_rsp(ln, bs, ad, rd), rd, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
